cpu_memunit: RTL and testbench

Load/store unit spanning pipeline stages P3 and P4. It latches P3 memory operations into P4 and checks each one for alignment and for data-memory-protection permissions against the eight `csr_dmpuN` registers driven by the exception unit. Legal accesses run over a single-outstanding data bus handshake. The block also formats load data, and drives the `p4_misaligned_address`, `p4_load_access_fault`, `p4_store_access_fault` and `p4_mem_addr` inputs of the exception unit.

---
 rtl/cpu_memunit.sv | 123 ++++++++++++
 tb/tb_cpu_memunit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memunit.sv
// cpu_memunit: P3/P4 load/store unit with alignment and DMPU checks, single-outstanding data bus
module cpu_memunit (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [5:0]  p3_op,
  input  logic [31:0] p3_mem_addr,
  input  logic [31:0] p3_wdata,
  input  logic        p4_jump_taken,
  input  logic        supervisor,
  input  logic [31:0] csr_dmpu0,
  input  logic [31:0] csr_dmpu1,
  input  logic [31:0] csr_dmpu2,
  input  logic [31:0] csr_dmpu3,
  input  logic [31:0] csr_dmpu4,
  input  logic [31:0] csr_dmpu5,
  input  logic [31:0] csr_dmpu6,
  input  logic [31:0] csr_dmpu7,
  output logic        dbus_request,
  output logic        dbus_write,
  output logic [31:0] dbus_address,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] p4_mem_addr,
  output logic [31:0] p4_load_data,
  output logic        p4_misaligned_address,
  output logic        p4_load_access_fault,
  output logic        p4_store_access_fault
);
  localparam logic [5:0] OP_LDB = 6'h20;
  localparam logic [5:0] OP_LDH = 6'h21;
  localparam logic [5:0] OP_LDW = 6'h23;
  localparam logic [5:0] OP_STB = 6'h28;
  localparam logic [5:0] OP_STH = 6'h29;
  localparam logic [5:0] OP_STW = 6'h2B;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [7:0][31:0] dmpu;
  logic [7:0] hit, rok, wok;
  logic p3_ld, p3_st, p3_mis, p3_perm, p3_valid, p3_legal;
  logic [5:0] p4_op;
  logic [31:0] p4_wdata, rsh, fmt;
  logic p4_valid, p4_st, busy;
  logic [1:0] state, state_nx;

  assign dmpu = {csr_dmpu7, csr_dmpu6, csr_dmpu5, csr_dmpu4, csr_dmpu3, csr_dmpu2, csr_dmpu1, csr_dmpu0};

  // a region only counts once its size exponent reaches a 4 KiB granule
  for (genvar g = 0; g < 8; g++) begin : g_rgn
    assign hit[g] = dmpu[g][4:0] >= 5'd12 &&
                    (p3_mem_addr >> dmpu[g][4:0]) == ({dmpu[g][31:12], 12'h0} >> dmpu[g][4:0]);
    assign rok[g] = hit[g] & dmpu[g][8];
    assign wok[g] = hit[g] & dmpu[g][9];
  end

  assign p3_ld    = p3_op == OP_LDB || p3_op == OP_LDH || p3_op == OP_LDW;
  assign p3_st    = p3_op == OP_STB || p3_op == OP_STH || p3_op == OP_STW;
  assign p3_valid = (p3_ld | p3_st) & ~p4_jump_taken;
  assign p3_mis   = ((p3_op == OP_LDH || p3_op == OP_STH) && p3_mem_addr[0]) ||
                    ((p3_op == OP_LDW || p3_op == OP_STW) && p3_mem_addr[1:0] != 2'b00);
  assign p3_perm  = supervisor | (p3_ld ? |rok : |wok);
  assign p3_legal = p3_valid & ~p3_mis & p3_perm;

  // P4 pipeline registers advance whenever the pipeline is not stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      p4_op <= '0;
      p4_mem_addr <= '0;
      p4_wdata <= '0;
      p4_valid <= 1'b0;
      p4_misaligned_address <= 1'b0;
      p4_load_access_fault <= 1'b0;
      p4_store_access_fault <= 1'b0;
    end else if (!stall) begin
      p4_op <= p3_op;
      p4_mem_addr <= p3_mem_addr;
      p4_wdata <= p3_wdata;
      p4_valid <= p3_valid;
      p4_misaligned_address <= p3_valid & p3_mis;
      p4_load_access_fault <= p3_valid & ~p3_mis & ~p3_perm & p3_ld;
      p4_store_access_fault <= p3_valid & ~p3_mis & ~p3_perm & p3_st;
    end
  end

  // BUSY is entered on the same edge that latches a legal op, so the request is up in its first P4 cycle
  always_comb begin
    state_nx = state == BUSY ? (dbus_ack ? DONE : BUSY) : stall ? state : p3_legal ? BUSY : IDLE;
  end

  // bus handshake state
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  assign rsh = dbus_rdata >> {p4_mem_addr[1:0], 3'b000};
  assign fmt = p4_op == OP_LDB ? {{24{rsh[7]}}, rsh[7:0]} :
               p4_op == OP_LDH ? {{16{rsh[15]}}, rsh[15:0]} : dbus_rdata;

  // load result is captured on the ack and held until the next completion
  always_ff @(posedge clock) begin
    if (reset) p4_load_data <= '0;
    else if (state == BUSY && dbus_ack) p4_load_data <= fmt;
  end

  assign busy         = state == BUSY && p4_valid;
  assign p4_st        = p4_op == OP_STB || p4_op == OP_STH || p4_op == OP_STW;
  assign mem_stall    = state == BUSY;
  assign dbus_request = busy;
  assign dbus_write   = busy & p4_st;
  assign dbus_address = busy ? {p4_mem_addr[31:2], 2'b00} : '0;
  assign dbus_wstrb   = !(busy && p4_st) ? 4'h0 :
                        p4_op == OP_STB ? 4'b0001 << p4_mem_addr[1:0] :
                        p4_op == OP_STH ? 4'b0011 << p4_mem_addr[1:0] : 4'hF;
  assign dbus_wdata   = !(busy && p4_st) ? '0 :
                        p4_op == OP_STB ? {4{p4_wdata[7:0]}} :
                        p4_op == OP_STH ? {2{p4_wdata[15:0]}} : p4_wdata;
endmodule

// File: tb/tb_cpu_memunit.sv
// tb_cpu_memunit: directed stimulus with a queue-based bus scoreboard for cpu_memunit
module tb_cpu_memunit;
  localparam logic [5:0] NOP    = 6'h00;
  localparam logic [5:0] OP_LDB = 6'h20;
  localparam logic [5:0] OP_LDH = 6'h21;
  localparam logic [5:0] OP_LDW = 6'h23;
  localparam logic [5:0] OP_STB = 6'h28;
  localparam logic [5:0] OP_STH = 6'h29;
  localparam logic [5:0] OP_STW = 6'h2B;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] ld;
  } exp_t;

  logic clock, reset, stall, p4_jump_taken, supervisor;
  logic [5:0] p3_op;
  logic [31:0] p3_mem_addr, p3_wdata;
  logic [31:0] csr_dmpu0, csr_dmpu1, csr_dmpu2, csr_dmpu3, csr_dmpu4, csr_dmpu5, csr_dmpu6, csr_dmpu7;
  logic dbus_request, dbus_write, dbus_ack, mem_stall;
  logic [31:0] dbus_address, dbus_wdata, dbus_rdata, p4_mem_addr, p4_load_data;
  logic [3:0] dbus_wstrb;
  logic p4_misaligned_address, p4_load_access_fault, p4_store_access_fault;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic in_txn = 1'b0;
  logic got_ack = 1'b0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic stray = 1'b0;
  logic [31:0] rdata_val = '0;
  logic s_mis, s_lf, s_sf, s_req;
  int n;

  cpu_memunit dut (
    .clock(clock), .reset(reset), .stall(stall), .p3_op(p3_op), .p3_mem_addr(p3_mem_addr),
    .p3_wdata(p3_wdata), .p4_jump_taken(p4_jump_taken), .supervisor(supervisor),
    .csr_dmpu0(csr_dmpu0), .csr_dmpu1(csr_dmpu1), .csr_dmpu2(csr_dmpu2), .csr_dmpu3(csr_dmpu3),
    .csr_dmpu4(csr_dmpu4), .csr_dmpu5(csr_dmpu5), .csr_dmpu6(csr_dmpu6), .csr_dmpu7(csr_dmpu7),
    .dbus_request(dbus_request), .dbus_write(dbus_write), .dbus_address(dbus_address),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .p4_mem_addr(p4_mem_addr), .p4_load_data(p4_load_data),
    .p4_misaligned_address(p4_misaligned_address), .p4_load_access_fault(p4_load_access_fault),
    .p4_store_access_fault(p4_store_access_fault)
  );

  assign stall = mem_stall;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // issue one op from P3, snapshot first-P4-cycle outputs, count stall cycles
  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, output int cnt);
    @(negedge clock);
    p3_op = op;
    p3_mem_addr = a;
    p3_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    p3_op = NOP;
    s_mis = p4_misaligned_address;
    s_lf = p4_load_access_fault;
    s_sf = p4_store_access_fault;
    s_req = dbus_request;
    cnt = 0;
    while (mem_stall && cnt < 50) begin
      cnt++;
      @(negedge clock);
    end
  endtask

  // bus responder: ack after ack_delay wait cycles, or one stray ack on demand
  initial begin
    dbus_ack = 1'b0;
    dbus_rdata = '0;
    forever begin
      @(negedge clock);
      dbus_ack = 1'b0;
      if (stray) begin
        dbus_ack = 1'b1;
        dbus_rdata = 32'hDEAD_BEEF;
        stray = 1'b0;
      end else if (dbus_request && !reset) begin
        if (wait_cnt >= ack_delay) begin
          dbus_ack = 1'b1;
          dbus_rdata = rdata_val;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  always @(posedge clock) got_ack <= dbus_ack && dbus_request;

  // monitor: pop an expectation at each new request, check load data after its ack
  initial begin
    forever begin
      @(negedge clock);
      if (got_ack && !cur.w) chk("load_data", p4_load_data, cur.ld);
      if (!dbus_request) in_txn = 1'b0;
      else if (!in_txn) begin
        in_txn = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request: got addr 0x%08h expected no request", dbus_address);
          cur = '{1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
        end else begin
          cur = exp_q.pop_front();
          chk("bus_write", {31'h0, dbus_write}, {31'h0, cur.w});
          chk("bus_addr", dbus_address, cur.a);
          if (cur.w) begin
            chk("bus_wstrb", {28'h0, dbus_wstrb}, {28'h0, cur.s});
            chk("bus_wdata", dbus_wdata, cur.d);
          end
        end
      end
    end
  end

  initial begin
    cur = '{1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
    reset = 1'b1;
    p3_op = NOP; p3_mem_addr = '0; p3_wdata = '0;
    p4_jump_taken = 1'b0; supervisor = 1'b0;
    {csr_dmpu0, csr_dmpu1, csr_dmpu2, csr_dmpu3} = '0;
    {csr_dmpu4, csr_dmpu5, csr_dmpu6, csr_dmpu7} = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req", {31'h0, dbus_request}, 32'h0);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_flags", {29'h0, p4_misaligned_address, p4_load_access_fault, p4_store_access_fault}, 32'h0);
    chk("rst_addr", p4_mem_addr, 32'h0);
    chk("rst_ldata", p4_load_data, 32'h0);
    reset = 1'b0;
    csr_dmpu0 = 32'h2000_0310;
    csr_dmpu1 = 32'h3000_0305;

    ack_delay = 2; rdata_val = 32'h8001_1234;
    exp_q.push_back('{1'b0, 32'h2000_0004, 4'h0, 32'h0, 32'hFFFF_8001});
    run(OP_LDH, 32'h2000_0006, 32'h0, n);
    chk("ldh_req_first_cycle", {31'h0, s_req}, 32'h1);
    chk("ldh_stall_cycles", n, 3);

    ack_delay = 0;
    exp_q.push_back('{1'b1, 32'h2000_0000, 4'b1000, 32'hABAB_ABAB, 32'h0});
    run(OP_STB, 32'h2000_0003, 32'h0000_00AB, n);
    chk("stb_stall_cycles", n, 1);

    exp_q.push_back('{1'b1, 32'h2000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0});
    run(OP_STH, 32'h2000_0002, 32'h1234_BEEF, n);
    chk("sth_stall_cycles", n, 1);

    ack_delay = 1; rdata_val = 32'h1122_F3AA;
    exp_q.push_back('{1'b0, 32'h2000_0000, 4'h0, 32'h0, 32'hFFFF_FFF3});
    run(OP_LDB, 32'h2000_0001, 32'h0, n);
    chk("ldb_stall_cycles", n, 2);

    ack_delay = 0; rdata_val = 32'h8765_4321;
    exp_q.push_back('{1'b0, 32'h2000_0008, 4'h0, 32'h0, 32'h8765_4321});
    run(OP_LDW, 32'h2000_0008, 32'h0, n);
    chk("ldw_stall_cycles", n, 1);

    run(OP_LDW, 32'h2000_0002, 32'h0, n);
    chk("mis_flags", {29'h0, s_mis, s_lf, s_sf}, 32'h4);
    chk("mis_no_req", {31'h0, s_req}, 32'h0);
    chk("mis_no_stall", n, 0);
    @(negedge clock);
    chk("mis_flag_clears", {31'h0, p4_misaligned_address}, 32'h0);

    csr_dmpu0 = 32'h2000_0110;
    run(OP_STW, 32'h2000_0100, 32'h1234_5678, n);
    chk("sfault_flags", {29'h0, s_mis, s_lf, s_sf}, 32'h1);
    chk("sfault_no_req", {31'h0, s_req}, 32'h0);
    chk("sfault_no_stall", n, 0);

    run(OP_LDW, 32'h3000_0000, 32'h0, n);
    chk("small_k_region_lfault", {29'h0, s_mis, s_lf, s_sf}, 32'h2);
    chk("lfault_no_req", {31'h0, s_req}, 32'h0);

    supervisor = 1'b1;
    exp_q.push_back('{1'b1, 32'h2000_0100, 4'hF, 32'h1234_5678, 32'h0});
    run(OP_STW, 32'h2000_0100, 32'h1234_5678, n);
    chk("sup_flags", {29'h0, s_mis, s_lf, s_sf}, 32'h0);
    chk("sup_stw_stall", n, 1);
    supervisor = 1'b0;

    p4_jump_taken = 1'b1;
    run(OP_LDW, 32'h2000_0000, 32'h0, n);
    p4_jump_taken = 1'b0;
    chk("jump_no_req", {31'h0, s_req}, 32'h0);
    chk("jump_no_stall", n, 0);
    chk("jump_no_flags", {29'h0, s_mis, s_lf, s_sf}, 32'h0);

    ack_delay = 99;
    exp_q.push_back('{1'b0, 32'h2000_0010, 4'h0, 32'h0, 32'h0});
    @(negedge clock);
    p3_op = OP_LDW; p3_mem_addr = 32'h2000_0010;
    @(posedge clock);
    @(negedge clock);
    p3_op = NOP;
    chk("busy_req", {31'h0, dbus_request}, 32'h1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy_req", {31'h0, dbus_request}, 32'h0);
    chk("rst_busy_stall", {31'h0, mem_stall}, 32'h0);
    #1 stray = 1'b1;
    repeat (3) @(negedge clock);
    chk("stray_ack_req", {31'h0, dbus_request}, 32'h0);
    chk("stray_ack_stall", {31'h0, mem_stall}, 32'h0);
    chk("stray_ack_ldata", p4_load_data, 32'h0);

    ack_delay = 0; rdata_val = 32'h0BAD_F00D;
    exp_q.push_back('{1'b0, 32'h2000_0000, 4'h0, 32'h0, 32'h0BAD_F00D});
    run(OP_LDW, 32'h2000_0000, 32'h0, n);
    chk("post_rst_ldw_stall", n, 1);
    repeat (2) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
